// File: rtl/kersram_r.sv
// rtl/kersram_r.sv - kernel SRAM read streamer feeding the PE array
// Lane 0 walks the kernel store once per pass; lanes 1..7 replay lane 0's issues through a delay chain.
module kersram_r #(
  parameter int ADDR_CNT_BITS = 10,
  parameter int KER_ST_LENGTH = 288,
  parameter int SRAM_LAT      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_ker_read,
  input  logic [7:0]               ker_read_pass_num,
  input  logic                     ker_read_stall,
  output logic                     ker_read_busy,
  output logic                     ker_read_done,
  output logic                     cen_kersr_0, cen_kersr_1, cen_kersr_2, cen_kersr_3,
  output logic                     cen_kersr_4, cen_kersr_5, cen_kersr_6, cen_kersr_7,
  output logic                     wen_kersr_0, wen_kersr_1, wen_kersr_2, wen_kersr_3,
  output logic                     wen_kersr_4, wen_kersr_5, wen_kersr_6, wen_kersr_7,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_0, addr_kersr_1, addr_kersr_2, addr_kersr_3,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_4, addr_kersr_5, addr_kersr_6, addr_kersr_7,
  input  logic [63:0]              dout_kersr_0, dout_kersr_1, dout_kersr_2, dout_kersr_3,
  input  logic [63:0]              dout_kersr_4, dout_kersr_5, dout_kersr_6, dout_kersr_7,
  output logic [63:0]              ker_data_0, ker_data_1, ker_data_2, ker_data_3,
  output logic [63:0]              ker_data_4, ker_data_5, ker_data_6, ker_data_7,
  output logic                     ker_valid_0, ker_valid_1, ker_valid_2, ker_valid_3,
  output logic                     ker_valid_4, ker_valid_5, ker_valid_6, ker_valid_7
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_CNT_BITS-1:0] LAST_ADDR = ADDR_CNT_BITS'(KER_ST_LENGTH - 1);
  localparam logic [3:0]               DRAIN_LEN = 4'(7 + SRAM_LAT);

  state_t                   state_q;
  logic [ADDR_CNT_BITS-1:0] addr_cnt_q;
  logic [7:0]               pass_cnt_q;
  logic [7:0]               npass_q;
  logic [3:0]               drain_cnt_q;
  logic [7:1]               iss_q;
  logic [ADDR_CNT_BITS-1:0] adr_q [1:7];
  logic [SRAM_LAT-1:0]      vld_q [8];

  logic                     en0;
  logic                     last_issue;
  logic [7:0]               lane_iss;
  logic [ADDR_CNT_BITS-1:0] lane_adr [8];

  assign en0        = (state_q == RUN) && !ker_read_stall;
  assign last_issue = en0 && (addr_cnt_q == LAST_ADDR) && (pass_cnt_q == npass_q - 8'd1);
  assign lane_iss   = {iss_q, en0};

  always_comb begin
    lane_adr[0] = addr_cnt_q;
    for (int k = 1; k < 8; k++) lane_adr[k] = adr_q[k];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      npass_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_ker_read) begin
          npass_q    <= (ker_read_pass_num == 8'd0) ? 8'd1 : ker_read_pass_num;
          addr_cnt_q <= '0;
          pass_cnt_q <= '0;
          state_q    <= RUN;
        end
        RUN: if (en0) begin
          if (addr_cnt_q == LAST_ADDR) begin
            addr_cnt_q <= '0;
            pass_cnt_q <= pass_cnt_q + 8'd1;
          end else begin
            addr_cnt_q <= addr_cnt_q + 1'b1;
          end
          if (last_issue) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 4'd1;
          end
        end
        // Hold long enough for lane 7's final read to come back out of the SRAM.
        DRAIN: if (drain_cnt_q == DRAIN_LEN) state_q <= DONE;
               else drain_cnt_q <= drain_cnt_q + 4'd1;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The chain is never frozen, so a stall bubble simply travels down the lanes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_q <= '0;
      for (int k = 1; k < 8; k++) adr_q[k] <= '0;
      for (int k = 0; k < 8; k++) vld_q[k] <= '0;
    end else begin
      iss_q    <= lane_iss[6:0];
      adr_q[1] <= addr_cnt_q;
      for (int k = 2; k < 8; k++) adr_q[k] <= adr_q[k-1];
      for (int k = 0; k < 8; k++) vld_q[k] <= (vld_q[k] << 1) | SRAM_LAT'(lane_iss[k]);
    end
  end

  assign ker_read_busy = (state_q == RUN) || (state_q == DRAIN);
  assign ker_read_done = (state_q == DONE);

  assign {cen_kersr_7, cen_kersr_6, cen_kersr_5, cen_kersr_4,
          cen_kersr_3, cen_kersr_2, cen_kersr_1, cen_kersr_0} = ~lane_iss;
  assign {wen_kersr_7, wen_kersr_6, wen_kersr_5, wen_kersr_4,
          wen_kersr_3, wen_kersr_2, wen_kersr_1, wen_kersr_0} = 8'hFF;

  assign addr_kersr_0 = lane_iss[0] ? lane_adr[0] : '0;
  assign addr_kersr_1 = lane_iss[1] ? lane_adr[1] : '0;
  assign addr_kersr_2 = lane_iss[2] ? lane_adr[2] : '0;
  assign addr_kersr_3 = lane_iss[3] ? lane_adr[3] : '0;
  assign addr_kersr_4 = lane_iss[4] ? lane_adr[4] : '0;
  assign addr_kersr_5 = lane_iss[5] ? lane_adr[5] : '0;
  assign addr_kersr_6 = lane_iss[6] ? lane_adr[6] : '0;
  assign addr_kersr_7 = lane_iss[7] ? lane_adr[7] : '0;

  assign ker_data_0 = dout_kersr_0;
  assign ker_data_1 = dout_kersr_1;
  assign ker_data_2 = dout_kersr_2;
  assign ker_data_3 = dout_kersr_3;
  assign ker_data_4 = dout_kersr_4;
  assign ker_data_5 = dout_kersr_5;
  assign ker_data_6 = dout_kersr_6;
  assign ker_data_7 = dout_kersr_7;

  assign ker_valid_0 = vld_q[0][SRAM_LAT-1];
  assign ker_valid_1 = vld_q[1][SRAM_LAT-1];
  assign ker_valid_2 = vld_q[2][SRAM_LAT-1];
  assign ker_valid_3 = vld_q[3][SRAM_LAT-1];
  assign ker_valid_4 = vld_q[4][SRAM_LAT-1];
  assign ker_valid_5 = vld_q[5][SRAM_LAT-1];
  assign ker_valid_6 = vld_q[6][SRAM_LAT-1];
  assign ker_valid_7 = vld_q[7][SRAM_LAT-1];

endmodule

// File: tb/tb_kersram_r.sv
// tb/tb_kersram_r.sv - randomized-stall bench for kersram_r against an issue-schedule model
module tb_kersram_r;
  localparam int L    = 288;
  localparam int TMAX = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pass_num;
  logic        stall;
  logic        busy, done;
  logic        cen [8];
  logic        wen [8];
  logic [9:0]  addr [8];
  logic [63:0] dout [8];
  logic [63:0] kdata [8];
  logic        kval [8];

  typedef struct { int t; logic [63:0] v; } ev_t;
  ev_t  obs_iss [8][$];
  ev_t  obs_val [8][$];
  int   done_t [$];
  bit   busy_tr [TMAX];
  bit   pat [TMAX];
  bit   mon_en = 1'b0;
  int   rel = 0;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  kersram_r dut (
    .clk(clk), .reset(reset), .start_ker_read(start), .ker_read_pass_num(pass_num),
    .ker_read_stall(stall), .ker_read_busy(busy), .ker_read_done(done),
    .cen_kersr_0(cen[0]), .cen_kersr_1(cen[1]), .cen_kersr_2(cen[2]), .cen_kersr_3(cen[3]),
    .cen_kersr_4(cen[4]), .cen_kersr_5(cen[5]), .cen_kersr_6(cen[6]), .cen_kersr_7(cen[7]),
    .wen_kersr_0(wen[0]), .wen_kersr_1(wen[1]), .wen_kersr_2(wen[2]), .wen_kersr_3(wen[3]),
    .wen_kersr_4(wen[4]), .wen_kersr_5(wen[5]), .wen_kersr_6(wen[6]), .wen_kersr_7(wen[7]),
    .addr_kersr_0(addr[0]), .addr_kersr_1(addr[1]), .addr_kersr_2(addr[2]), .addr_kersr_3(addr[3]),
    .addr_kersr_4(addr[4]), .addr_kersr_5(addr[5]), .addr_kersr_6(addr[6]), .addr_kersr_7(addr[7]),
    .dout_kersr_0(dout[0]), .dout_kersr_1(dout[1]), .dout_kersr_2(dout[2]), .dout_kersr_3(dout[3]),
    .dout_kersr_4(dout[4]), .dout_kersr_5(dout[5]), .dout_kersr_6(dout[6]), .dout_kersr_7(dout[7]),
    .ker_data_0(kdata[0]), .ker_data_1(kdata[1]), .ker_data_2(kdata[2]), .ker_data_3(kdata[3]),
    .ker_data_4(kdata[4]), .ker_data_5(kdata[5]), .ker_data_6(kdata[6]), .ker_data_7(kdata[7]),
    .ker_valid_0(kval[0]), .ker_valid_1(kval[1]), .ker_valid_2(kval[2]), .ker_valid_3(kval[3]),
    .ker_valid_4(kval[4]), .ker_valid_5(kval[5]), .ker_valid_6(kval[6]), .ker_valid_7(kval[7])
  );

  // SRAM lane k, address a holds {k, a}; one-cycle read latency.
  always @(posedge clk)
    for (int k = 0; k < 8; k++)
      if (!cen[k]) dout[k] <= {32'(k), 32'(addr[k])};

  always @(negedge clk)
    if (mon_en) begin
      for (int k = 0; k < 8; k++) begin
        if (!cen[k]) obs_iss[k].push_back('{rel, 64'(addr[k])});
        if (kval[k]) obs_val[k].push_back('{rel, kdata[k]});
      end
      if (done) done_t.push_back(rel);
      if (rel < TMAX) busy_tr[rel] = busy;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_cen%0d", tag, k), 64'(cen[k]), 64'd1);
      chk($sformatf("%s_wen%0d", tag, k), 64'(wen[k]), 64'd1);
      chk($sformatf("%s_addr%0d", tag, k), 64'(addr[k]), 64'd0);
      chk($sformatf("%s_valid%0d", tag, k), 64'(kval[k]), 64'd0);
    end
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Model: lane 0 issues on every non-stalled RUN cycle starting the cycle after start,
  // addresses cycle 0..L-1 once per pass; lane k repeats each issue k cycles later,
  // data follows one cycle after the issue, done follows lane 7's last valid.
  task automatic run_check(input int np_in, input int stall_pct, input int glitch_at,
                           output int done_exp);
    int np, total, t, tlast, endt, m;
    int et [$];
    np    = (np_in == 0) ? 1 : np_in;
    total = L * np;
    for (int i = 0; i < TMAX; i++) pat[i] = ($urandom_range(99) < stall_pct);
    t = 1;
    while (et.size() < total) begin
      if (!pat[t]) et.push_back(t);
      t++;
    end
    tlast    = et[$];
    endt     = tlast + 12;
    done_exp = tlast + 9;
    for (int k = 0; k < 8; k++) begin obs_iss[k].delete(); obs_val[k].delete(); end
    done_t.delete();

    rel = 0; mon_en = 1'b1;
    pass_num = 8'(np_in); start = 1'b1; stall = pat[0];
    @(posedge clk); #1;
    for (int r = 1; r <= endt; r++) begin
      rel      = r;
      stall    = pat[r];
      start    = (r == glitch_at);
      pass_num = (r == glitch_at) ? 8'(np_in + 2) : 8'(np_in);
      @(posedge clk); #1;
    end
    mon_en = 1'b0; start = 1'b0; stall = 1'b0;

    chk("done_count", 64'(done_t.size()), 64'd1);
    if (done_t.size() > 0) chk("done_time", 64'(done_t[0]), 64'(done_exp));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("iss_count%0d", k), 64'(obs_iss[k].size()), 64'(total));
      chk($sformatf("val_count%0d", k), 64'(obs_val[k].size()), 64'(total));
      m = (obs_iss[k].size() < total) ? obs_iss[k].size() : total;
      for (int n = 0; n < m; n++) begin
        chk($sformatf("iss_t%0d_%0d", k, n), 64'(obs_iss[k][n].t), 64'(et[n] + k));
        chk($sformatf("iss_a%0d_%0d", k, n), obs_iss[k][n].v, 64'(n % L));
      end
      m = (obs_val[k].size() < total) ? obs_val[k].size() : total;
      for (int n = 0; n < m; n++) begin
        chk($sformatf("val_t%0d_%0d", k, n), 64'(obs_val[k][n].t), 64'(et[n] + k + 1));
        chk($sformatf("val_d%0d_%0d", k, n), obs_val[k][n].v, {32'(k), 32'(n % L)});
      end
    end
    for (int r = 0; r <= endt; r++)
      chk($sformatf("busy_%0d", r), 64'(busy_tr[r]), 64'(r >= 1 && r <= tlast + 8));
  endtask

  initial begin
    int de;
    reset = 1'b0; start = 1'b0; stall = 1'b0; pass_num = 8'd0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

    run_check(1, 0, -1, de);
    chk("nostall_done_cycle", 64'(de), 64'd297);
    run_check(3, 0, -1, de);
    run_check(0, 0, -1, de);
    run_check(2, 30, -1, de);
    run_check(1, 45, -1, de);
    run_check($urandom_range(1, 3), 20, 150, de);

    // Abort at cycle 100 of a run, then confirm a clean restart.
    pass_num = 8'd1; start = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 1; r <= 100; r++) begin
      if (r == 100) reset = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_%0d", r), 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    run_check(1, 25, -1, de);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
